// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: 2-flop synchronizer, per-bit debounce counter, edge pulses.
// Optional SW_CHANGE_CNT_EN macro adds a saturating 16-bit count of sw_changed cycles.
`timescale 1ns/1ps
module sw_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`ifdef SW_CHANGE_CNT_EN
    output logic [15:0]      change_cnt,
`endif
    output logic             sw_changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit counts only while its synchronized level disagrees with the accepted level.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            out_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= sw_in;
            sync2_q   <= sync1_q;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_out     = out_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;

`ifdef SW_CHANGE_CNT_EN
    logic [15:0] cc_q, cc_d;

    // Counts change cycles, not changed bits; sticks at all-ones.
    always_comb begin
        cc_d = cc_q;
        if (changed_q && (cc_q != 16'hFFFF)) begin
            cc_d = cc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign change_cnt = cc_q;
`endif

endmodule
